// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and data (load/store) share one memory port.
// Define MEM_ARB_RR_EN to replace fixed data priority on ties with round-robin arbitration.
module mem_arb #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  // A latency of 0 behaves as 1; anything beyond the 4-bit counter saturates at 15.
  localparam int EFF_LAT = (MEM_LAT < 1) ? 1 : ((MEM_LAT > 15) ? 15 : MEM_LAT);
  localparam logic [3:0] CNT_LOAD = 4'(EFF_LAT - 1);

  typedef enum logic [1:0] {IDLE, IACC, DACC, ACK} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] addr_reg, addr_next;
  logic        we_reg, we_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        gnt_d_reg, gnt_d_next;
  logic [31:0] if_rdata_reg, if_rdata_next;
  logic [31:0] d_rdata_reg, d_rdata_next;
  logic        grant_d;

`ifdef MEM_ARB_RR_EN
  // last_d_reg = 1 when the most recent grant went to the data port.
  logic last_d_reg, last_d_next;

  assign grant_d = d_req & (~if_req | ~last_d_reg);

  always_comb begin
    last_d_next = last_d_reg;
    if (state_reg == IDLE && (d_req || if_req)) begin
      last_d_next = grant_d;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      last_d_reg <= 1'b0;
    end else begin
      last_d_reg <= last_d_next;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= 16'd0;
      we_reg       <= 1'b0;
      wdata_reg    <= 32'd0;
      gnt_d_reg    <= 1'b0;
      if_rdata_reg <= 32'd0;
      d_rdata_reg  <= 32'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      wdata_reg    <= wdata_next;
      gnt_d_reg    <= gnt_d_next;
      if_rdata_reg <= if_rdata_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    we_next       = we_reg;
    wdata_next    = wdata_reg;
    gnt_d_next    = gnt_d_reg;
    if_rdata_next = if_rdata_reg;
    d_rdata_next  = d_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (d_req || if_req) begin
          cnt_next   = CNT_LOAD;
          gnt_d_next = grant_d;
          if (grant_d) begin
            state_next = DACC;
            addr_next  = d_addr;
            we_next    = d_we;
            wdata_next = d_wdata;
          end else begin
            state_next = IACC;
            addr_next  = if_addr;
            we_next    = 1'b0;
            wdata_next = 32'd0;
          end
        end
      end
      IACC, DACC: begin
        if (cnt_reg == 4'd0) begin
          state_next = ACK;
          // mem_rdata is only valid on the final access cycle.
          if (state_reg == IACC) begin
            if_rdata_next = mem_rdata;
          end else if (!we_reg) begin
            d_rdata_next = mem_rdata;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ACK: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign mem_en    = (state_reg == IACC) || (state_reg == DACC);
  assign mem_we    = (state_reg == DACC) && we_reg;
  assign mem_addr  = mem_en ? addr_reg : 16'd0;
  assign mem_wdata = (state_reg == DACC) ? wdata_reg : 32'd0;
  assign if_ack    = (state_reg == ACK) && !gnt_d_reg;
  assign d_ack     = (state_reg == ACK) && gnt_d_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter MEM_LAT, default 2, memory access latency in cycles; legal range 1..15; a value of 0 SHALL be treated as 1.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_f  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch request, held high until if_ack.
REQ-005 if_addr  input  16  instruction-fetch word address.
REQ-006 if_ack  output  1  one-cycle pulse: fetch done, if_rdata valid.
REQ-007 if_rdata  output  32  fetched instruction word.
REQ-008 d_req  input  1  data request (LOD/STR), held high until d_ack.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  16  data word address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ack  output  1  one-cycle pulse: data access done.
REQ-013 d_rdata  output  32  load data.
REQ-014 mem_en  output  1  memory enable.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  16  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data, valid on the last cycle of mem_en.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, IACC, DACC, ACK.
REQ-021 IDLE: d_req=1 -> DACC; else if_req=1 -> IACC; else stay; requests SHALL be sampled only in IDLE.
REQ-022 On grant edge: latch addr (and d_we, d_wdata for data); later input changes SHALL NOT affect the access.
REQ-023 IACC/DACC: 4-bit counter loaded with MEM_LAT-1, decremented each cycle; mem_en=1 and mem_addr=latched addr for exactly MEM_LAT cycles; at count 0 -> ACK.
REQ-024 mem_we=1 only in DACC with latched d_we=1; mem_wdata=latched d_wdata in DACC, 0 otherwise.
REQ-025 On the last access cycle of a read, mem_rdata SHALL be captured into if_rdata (IACC) or d_rdata (DACC load).
REQ-026 ACK: pulse if_ack or d_ack for the granted port for exactly one cycle, mem_en=0, then -> IDLE.
REQ-027 Latency: request sampled at edge N -> mem_en high cycles N+1..N+MEM_LAT -> ack high cycle N+MEM_LAT+1; max throughput one access per MEM_LAT+2 cycles.
REQ-028 if_rdata/d_rdata SHALL hold their value until overwritten by the next read on that port; a store SHALL NOT modify d_rdata.
REQ-029 Request withdrawn mid-access: access completes and ack still pulses.
REQ-030 Simultaneous if_req and d_req in IDLE: data wins (fixed priority) unless REQ-035 applies.
REQ-031 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-032 rst_f=0 SHALL immediately force IDLE, counter 0, and all outputs to 0 (acks, rdata, mem_*, busy), regardless of clk.
REQ-033 Reset mid-access SHALL abort it with no ack; after release the requester SHALL re-request.
REQ-034 First grant possible on the first rising edge after rst_f goes high.

Configuration
REQ-035 MEM_ARB_RR_EN defined: simultaneous requests alternate round-robin via a last-grant bit (reset value = IF, so data wins first tie); a lone request is always granted.
REQ-036 MEM_ARB_RR_EN undefined: fixed data priority per REQ-030; no last-grant register.

Verification
REQ-037 MEM_LAT=2, if_req, if_addr=0x0010, mem_rdata=0x2000_0001 -> mem_en cycles 1-2 with mem_addr=0x0010, if_ack cycle 3, if_rdata=0x2000_0001.
REQ-038 d_req, d_we=1, d_addr=0x0080, d_wdata=0xDEAD_BEEF -> mem_we=1 for 2 cycles, d_ack once, d_rdata unchanged.
REQ-039 if_req and d_req asserted in the same cycle, held -> without macro: DACC, then IACC; with MEM_ARB_RR_EN: DACC, IACC, DACC alternating.
REQ-040 rst_f pulled low on the 2nd DACC cycle -> mem_en/busy 0 at once, no d_ack, IDLE after release.
REQ-041 MEM_LAT=0 and MEM_LAT=15 -> mem_en high for 1 and 15 cycles respectively; ack one cycle later.
